// File: rtl/axi4_sram_slave.sv
// AXI4 leaf slave backed by a word-wide SRAM array.
// Independent read and write FSMs, FIXED/INCR/WRAP addressing, byte strobes, SLVERR on bad bursts.
module axi4_sram_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MEM_BYTES  = 4096
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int SIZE_MAX = $clog2(STRB_W);
    localparam int DEPTH    = MEM_BYTES / STRB_W;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int EW       = ADDR_WIDTH + 17;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [7:0]            len
    );
        logic [ADDR_WIDTH-1:0] bytes, span, lower, result;
        bytes  = ADDR_WIDTH'(1) << size;
        span   = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        lower  = addr & ~(span - ADDR_WIDTH'(1));
        case (burst)
            BURST_FIXED: result = addr;
            BURST_WRAP:  result = lower + ((addr + bytes - lower) & (span - ADDR_WIDTH'(1)));
            default:     result = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        endcase
        return result;
    endfunction

    // Evaluated once at the address handshake; extra width keeps the end-of-burst sum from wrapping.
    function automatic logic burst_err(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [7:0]            len
    );
        logic [EW-1:0] a, bytes, span, aligned, lower, first_b, last_b, base, top;
        logic          bad;
        a       = EW'(addr);
        bytes   = EW'(1) << size;
        span    = bytes * (EW'(len) + EW'(1));
        aligned = a & ~(bytes - EW'(1));
        lower   = a & ~(span - EW'(1));
        first_b = a;
        last_b  = aligned + span - EW'(1);
        if (burst == BURST_FIXED) begin
            last_b = aligned + bytes - EW'(1);
        end else if (burst == BURST_WRAP) begin
            first_b = lower;
            last_b  = lower + span - EW'(1);
        end
        base = EW'(BASE_ADDR);
        top  = base + EW'(MEM_BYTES);
        bad  = (first_b < base) || (last_b >= top) || (size > 3'(SIZE_MAX)) || (burst == 2'b11);
        if (burst == BURST_WRAP) begin
            bad = bad || !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))
                      || ((a & (bytes - EW'(1))) != '0);
        end
        return bad;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> SIZE_MAX);
    endfunction

    // ---------------- storage: one byte-wide array per lane ----------------
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            always_ff @(posedge ACLK) begin
                if (wr_en && WSTRB[gi]) begin
                    mem_lane[wr_idx] <= WDATA[gi*8 +: 8];
                end
            end
            assign rd_word[gi*8 +: 8] = mem_lane[rd_idx];
        end
    endgenerate

    // ---------------- write channel ----------------
    w_state_t              w_state_reg, w_state_next;
    logic                  awready_reg, awready_next;
    logic                  wready_reg, wready_next;
    logic                  bvalid_reg, bvalid_next;
    logic [ID_WIDTH-1:0]   bid_reg, bid_next;
    logic [1:0]            bresp_reg, bresp_next;
    logic [ID_WIDTH-1:0]   w_id_reg, w_id_next;
    logic [ADDR_WIDTH-1:0] w_addr_reg, w_addr_next;
    logic [2:0]            w_size_reg, w_size_next;
    logic [1:0]            w_burst_reg, w_burst_next;
    logic [7:0]            w_len_reg, w_len_next;
    logic [7:0]            w_cnt_reg, w_cnt_next;
    logic                  w_err_reg, w_err_next;
    logic                  w_last_err_reg, w_last_err_next;
    logic                  aw_err;

    assign aw_err = burst_err(AWADDR, AWSIZE, AWBURST, AWLEN);
    assign wr_idx = word_idx(w_addr_reg);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_reg    <= W_IDLE;
            awready_reg    <= 1'b0;
            wready_reg     <= 1'b0;
            bvalid_reg     <= 1'b0;
            bid_reg        <= '0;
            bresp_reg      <= '0;
            w_id_reg       <= '0;
            w_addr_reg     <= '0;
            w_size_reg     <= '0;
            w_burst_reg    <= '0;
            w_len_reg      <= '0;
            w_cnt_reg      <= '0;
            w_err_reg      <= 1'b0;
            w_last_err_reg <= 1'b0;
        end else begin
            w_state_reg    <= w_state_next;
            awready_reg    <= awready_next;
            wready_reg     <= wready_next;
            bvalid_reg     <= bvalid_next;
            bid_reg        <= bid_next;
            bresp_reg      <= bresp_next;
            w_id_reg       <= w_id_next;
            w_addr_reg     <= w_addr_next;
            w_size_reg     <= w_size_next;
            w_burst_reg    <= w_burst_next;
            w_len_reg      <= w_len_next;
            w_cnt_reg      <= w_cnt_next;
            w_err_reg      <= w_err_next;
            w_last_err_reg <= w_last_err_next;
        end
    end

    always_comb begin
        w_state_next    = w_state_reg;
        awready_next    = awready_reg;
        wready_next     = wready_reg;
        bvalid_next     = bvalid_reg;
        bid_next        = bid_reg;
        bresp_next      = bresp_reg;
        w_id_next       = w_id_reg;
        w_addr_next     = w_addr_reg;
        w_size_next     = w_size_reg;
        w_burst_next    = w_burst_reg;
        w_len_next      = w_len_reg;
        w_cnt_next      = w_cnt_reg;
        w_err_next      = w_err_reg;
        w_last_err_next = w_last_err_reg;
        wr_en           = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                awready_next = 1'b1;
                if (AWVALID && awready_reg) begin
                    w_id_next       = AWID;
                    w_addr_next     = AWADDR;
                    w_size_next     = AWSIZE;
                    w_burst_next    = AWBURST;
                    w_len_next      = AWLEN;
                    w_cnt_next      = '0;
                    w_err_next      = aw_err;
                    w_last_err_next = 1'b0;
                    awready_next    = 1'b0;
                    wready_next     = 1'b1;
                    w_state_next    = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && wready_reg) begin
                    wr_en       = !w_err_reg;
                    w_addr_next = next_addr(w_addr_reg, w_size_reg, w_burst_reg, w_len_reg);
                    w_cnt_next  = 8'(w_cnt_reg + 8'd1);
                    if (WLAST != (w_cnt_reg == w_len_reg)) begin
                        w_last_err_next = 1'b1;
                    end
                    // The beat count ends the burst; WLAST only affects the response.
                    if (w_cnt_reg == w_len_reg) begin
                        wready_next  = 1'b0;
                        bvalid_next  = 1'b1;
                        bid_next     = w_id_reg;
                        bresp_next   = (w_err_reg || w_last_err_next) ? RESP_SLVERR : RESP_OKAY;
                        w_state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (BREADY && bvalid_reg) begin
                    bvalid_next  = 1'b0;
                    awready_next = 1'b1;
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // ---------------- read channel ----------------
    r_state_t              r_state_reg, r_state_next;
    logic                  arready_reg, arready_next;
    logic                  rvalid_reg, rvalid_next;
    logic                  rlast_reg, rlast_next;
    logic [ID_WIDTH-1:0]   rid_reg, rid_next;
    logic [1:0]            rresp_reg, rresp_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic [ADDR_WIDTH-1:0] r_addr_reg, r_addr_next;
    logic [2:0]            r_size_reg, r_size_next;
    logic [1:0]            r_burst_reg, r_burst_next;
    logic [7:0]            r_len_reg, r_len_next;
    logic [7:0]            r_cnt_reg, r_cnt_next;
    logic                  r_err_reg, r_err_next;
    logic                  ar_err;
    logic [ADDR_WIDTH-1:0] r_addr_adv;

    assign ar_err     = burst_err(ARADDR, ARSIZE, ARBURST, ARLEN);
    assign r_addr_adv = next_addr(r_addr_reg, r_size_reg, r_burst_reg, r_len_reg);
    // In IDLE the array is addressed by ARADDR so the first beat loads on the handshake edge.
    assign rd_idx     = word_idx((r_state_reg == R_IDLE) ? ARADDR : r_addr_adv);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rid_reg     <= '0;
            rresp_reg   <= '0;
            rdata_reg   <= '0;
            r_addr_reg  <= '0;
            r_size_reg  <= '0;
            r_burst_reg <= '0;
            r_len_reg   <= '0;
            r_cnt_reg   <= '0;
            r_err_reg   <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
            rlast_reg   <= rlast_next;
            rid_reg     <= rid_next;
            rresp_reg   <= rresp_next;
            rdata_reg   <= rdata_next;
            r_addr_reg  <= r_addr_next;
            r_size_reg  <= r_size_next;
            r_burst_reg <= r_burst_next;
            r_len_reg   <= r_len_next;
            r_cnt_reg   <= r_cnt_next;
            r_err_reg   <= r_err_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        arready_next = arready_reg;
        rvalid_next  = rvalid_reg;
        rlast_next   = rlast_reg;
        rid_next     = rid_reg;
        rresp_next   = rresp_reg;
        rdata_next   = rdata_reg;
        r_addr_next  = r_addr_reg;
        r_size_next  = r_size_reg;
        r_burst_next = r_burst_reg;
        r_len_next   = r_len_reg;
        r_cnt_next   = r_cnt_reg;
        r_err_next   = r_err_reg;
        case (r_state_reg)
            R_IDLE: begin
                arready_next = 1'b1;
                if (ARVALID && arready_reg) begin
                    arready_next = 1'b0;
                    r_addr_next  = ARADDR;
                    r_size_next  = ARSIZE;
                    r_burst_next = ARBURST;
                    r_len_next   = ARLEN;
                    r_cnt_next   = '0;
                    r_err_next   = ar_err;
                    rdata_next   = ar_err ? '0 : rd_word;
                    rresp_next   = ar_err ? RESP_SLVERR : RESP_OKAY;
                    rvalid_next  = 1'b1;
                    rlast_next   = (ARLEN == 8'd0);
                    rid_next     = ARID;
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY && rvalid_reg) begin
                    if (rlast_reg) begin
                        rvalid_next  = 1'b0;
                        rlast_next   = 1'b0;
                        arready_next = 1'b1;
                        r_state_next = R_IDLE;
                    end else begin
                        r_addr_next = r_addr_adv;
                        r_cnt_next  = 8'(r_cnt_reg + 8'd1);
                        rdata_next  = r_err_reg ? '0 : rd_word;
                        rlast_next  = (8'(r_cnt_reg + 8'd1) == r_len_reg);
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign AWREADY = awready_reg;
    assign WREADY  = wready_reg;
    assign BVALID  = bvalid_reg;
    assign BID     = bid_reg;
    assign BRESP   = bresp_reg;
    assign ARREADY = arready_reg;
    assign RVALID  = rvalid_reg;
    assign RLAST   = rlast_reg;
    assign RID     = rid_reg;
    assign RRESP   = rresp_reg;
    assign RDATA   = rdata_reg;

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
- Parametrised AXI4 memory slave with an internal word-wide SRAM array. Successor to the single-byte, single-FSM SRAM slave.
- Adds configurable data width, byte strobes, correct FIXED/INCR/WRAP burst addressing, narrow transfers, a proper RLAST, and SLVERR reporting.
- Read and write channels are served by independent FSMs, so they run concurrently.
- Sits on the AXI interconnect as a leaf slave at BASE_ADDR.

Parameters:
- DATA_WIDTH, 32: data bus width in bits; one of 32, 64, 128.
- ADDR_WIDTH, 32: AXI address width.
- ID_WIDTH, 4: AWID/ARID/BID/RID width.
- BASE_ADDR, 0: first byte address decoded by this slave.
- MEM_BYTES, 4096: memory size in bytes; power of two; multiple of DATA_WIDTH/8.

Ports:
- ACLK  in  1  clock; all logic samples on the rising edge
- ARESETn  in  1  asynchronous active-low reset
- AWID  in  ID_WIDTH  write ID
- AWADDR  in  ADDR_WIDTH  write start byte address
- AWLEN  in  8  beats minus 1
- AWSIZE  in  3  log2 of bytes per beat
- AWBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP
- AWVALID  in  1 / AWREADY  out  1  write address handshake
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte enables
- WLAST  in  1  last write beat marker
- WVALID  in  1 / WREADY  out  1  write data handshake
- BID  out  ID_WIDTH  response ID
- BRESP  out  2  write response
- BVALID  out  1 / BREADY  in  1  write response handshake
- ARID, ARADDR, ARLEN, ARSIZE, ARBURST  in  same widths as the AW equivalents
- ARVALID  in  1 / ARREADY  out  1  read address handshake
- RID  out  ID_WIDTH  read ID
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- RLAST  out  1  last read beat marker
- RVALID  out  1 / RREADY  in  1  read data handshake

Behaviour:
- Reset:
  - Asynchronous and active-low. All outputs are registered and reset to 0; both FSMs go to IDLE.
  - AWREADY and ARREADY rise at the first ACLK edge after ARESETn deasserts.
  - Memory contents are not reset and are retained across reset.
  - Reset mid-burst aborts the burst with no response; no partial-beat writes occur after reset asserts.
- Response codes: OKAY = 00, SLVERR = 10.
- Burst check, performed at the AW/AR handshake. The transaction is in error (SLVERR for the whole burst) if any of the following holds:
  - start address < BASE_ADDR;
  - last byte touched ≥ BASE_ADDR + MEM_BYTES;
  - 2^AxSIZE > DATA_WIDTH/8;
  - AxBURST = 11;
  - WRAP with a length other than 2, 4, 8 or 16 beats;
  - WRAP with an unaligned start address.
- Error handling: erroneous bursts still complete every handshake. Writes are suppressed; reads return RDATA = 0.
- Address sequence, with B = 2^AxSIZE:
  - FIXED: every beat uses the start address.
  - INCR: beat n uses align(start, B) + n·B; beat 0 uses start.
  - WRAP: with span = B·(len+1) and lower = start & ~(span−1), next = lower + ((addr + B − lower) mod span).
- Array access:
  - Word index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8).
  - Only bytes with WSTRB=1 are written. Narrow lane selection is the master's responsibility via WSTRB.
  - RDATA is the full word.
- Write FSM:
  - W_IDLE (AWREADY=1): on AW handshake, latch the burst, clear the beat counter, AWREADY←0, WREADY←1, go to W_DATA.
  - W_DATA: on each W handshake, write the array, advance the address, increment the counter.
    - On beat AWLEN: WREADY←0, BVALID←1, BID←latched ID, go to W_RESP.
    - Throughput is 1 beat per cycle.
  - W_RESP: hold BVALID/BID/BRESP until BREADY. Then BVALID←0, AWREADY←1, go to W_IDLE.
  - BRESP = SLVERR if the burst check failed, or if WLAST disagrees with the beat count on any beat. The beat count, not WLAST, terminates the burst.
- Read FSM:
  - R_IDLE (ARREADY=1): on AR handshake, ARREADY←0, RDATA←word(start), RVALID←1, RLAST←(ARLEN==0), RID←ARID, go to R_DATA. First RVALID is 1 cycle after the handshake.
  - R_DATA:
    - On an R handshake with RLAST=1: RVALID←0, RLAST←0, ARREADY←1, go to R_IDLE.
    - On an R handshake with RLAST=0: load the next beat, RLAST←(next beat == ARLEN).
    - With RREADY held high, beats are back-to-back.
    - While RVALID=1 and RREADY=0, RDATA/RLAST/RRESP/RID stay stable.
- Concurrency: read and write channels are fully independent. A same-edge write and read-load of one word returns the old data.

Test Plan:
- INCR write AWADDR=0x010, AWSIZE=2, AWLEN=3, data 0x11111111..0x44444444, WSTRB=F, AWID=5 → BRESP=00, BID=5. INCR read of the same burst → 4 beats in order, RLAST only on beat 4, RID=ARID.
- WRAP write AWADDR=0x038, AWSIZE=2, AWLEN=3, data A, B, C, D → array words at 0x38=A, 0x3C=B, 0x30=C, 0x34=D. INCR read from 0x030 → C, D, A, B.
- Word 0x100 preset to 0x00000000, then write 0xAABBCCDD with WSTRB=0101 → read returns 0x00BB00DD.
- Each of the following → BRESP/RRESP=10 on every beat, with no memory change and RDATA=0:
  - AWADDR=0xFFC, AWSIZE=2, AWLEN=1;
  - ARBURST=WRAP with ARLEN=2;
  - AWSIZE=3 with DATA_WIDTH=32.
- Concurrent 8-beat write and 8-beat read to disjoint regions, with RREADY toggling 1010… and BREADY delayed 3 cycles → both complete; RDATA is stable during stalls; BVALID is held.
- ARESETn pulled low in W_DATA beat 2 and R_DATA beat 1 → all outputs 0 asynchronously. After release, AWREADY=ARREADY=1 at the next edge, and a fresh single-beat write/read to 0x020 returns OKAY with correct data.
